// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller.
// Stall requests are prioritised by how deep they freeze the pipe. A flush
// older than the stall point waits until the stall clears or shrinks.
// Also provides bubble insertion, performance counters and a stall watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned          STAGES     = 6,
  parameter int unsigned          NREQ       = 4,
  parameter logic [4*NREQ-1:0]    REQ_DEPTH  = 16'h4221,
  parameter int unsigned          AW         = 32,
  parameter int unsigned          CW         = 32,
  parameter int unsigned          WDOG_LIMIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_stall_req,
  input  logic              i_flush_req,
  input  logic [2:0]        i_flush_stage,
  input  logic [AW-1:0]     i_flush_pc,
  input  logic              i_cnt_clr,
  output logic [STAGES-1:0] o_stall,
  output logic [STAGES-1:0] o_bubble,
  output logic [STAGES-1:0] o_flush,
  output logic [AW-1:0]     o_flush_pc,
  output logic              o_flush_pending,
  output logic [CW-1:0]     o_stall_cycles,
  output logic [CW-1:0]     o_flush_count,
  output logic              o_wdog_err
);

  localparam logic [3:0]  LAST   = 4'(STAGES - 1);
  localparam logic [31:0] WD_LIM = WDOG_LIMIT;

  logic              w_any;
  logic [3:0]        w_d;
  logic [3:0]        w_dmax;
  logic [3:0]        w_new_fs;
  logic              w_take_new;
  logic              w_eff_valid;
  logic [3:0]        w_eff_fs;
  logic [AW-1:0]     w_eff_pc;
  logic              w_apply;
  logic              w_defer;

  logic              r_pend;
  logic [3:0]        r_pend_fs;
  logic [AW-1:0]     r_pend_pc;
  logic [AW-1:0]     r_flush_pc;
  logic [CW-1:0]     r_stall_cycles;
  logic [CW-1:0]     r_flush_count;
  logic [31:0]       r_wdog_cnt;
  logic              r_wdog_err;

  // Deepest frozen stage over all active requests, each depth clamped to the last stage.
  always_comb begin
    w_any  = 1'b0;
    w_d    = '0;
    w_dmax = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (i_stall_req[i]) begin
        w_any = 1'b1;
        w_d   = REQ_DEPTH[4*i +: 4];
        if (w_d > LAST) w_d = LAST;
        if (w_d > w_dmax) w_dmax = w_d;
      end
    end
  end

  // Pick the effective flush (new vs. pending, larger stage wins, ties go to new) and decide.
  always_comb begin
    w_new_fs    = ({1'b0, i_flush_stage} > LAST) ? LAST : {1'b0, i_flush_stage};
    w_take_new  = i_flush_req && !(r_pend && (r_pend_fs > w_new_fs));
    w_eff_valid = i_flush_req || r_pend;
    w_eff_fs    = w_take_new ? w_new_fs : r_pend_fs;
    w_eff_pc    = w_take_new ? i_flush_pc : r_pend_pc;
    w_apply     = !i_rst && w_eff_valid && (!w_any || (w_eff_fs >= w_dmax));
    w_defer     = !i_rst && w_eff_valid && !w_apply;
  end

  // Per-stage hold/bubble/kill; an applied flush overrides any stall that cycle.
  always_comb begin
    o_stall  = '0;
    o_bubble = '0;
    o_flush  = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (!i_rst && !w_apply && w_any) begin
        o_stall[k]  = (4'(k) <= w_dmax);
        o_bubble[k] = ({1'b0, w_dmax} + 5'd1 == 5'(k));
      end
      if (w_apply) o_flush[k] = (4'(k) <= w_eff_fs);
    end
    o_flush_pc      = w_apply ? w_eff_pc : r_flush_pc;
    o_flush_pending = w_defer;
    o_stall_cycles  = r_stall_cycles;
    o_flush_count   = r_flush_count;
    o_wdog_err      = r_wdog_err;
  end

  // Deferred flush entry, last redirect address, counters and watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend         <= 1'b0;
      r_pend_fs      <= '0;
      r_pend_pc      <= '0;
      r_flush_pc     <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wdog_cnt     <= '0;
      r_wdog_err     <= 1'b0;
    end else begin
      r_pend <= w_defer;
      if (w_defer) begin
        r_pend_fs <= w_eff_fs;
        r_pend_pc <= w_eff_pc;
      end
      if (w_apply) r_flush_pc <= w_eff_pc;

      if (i_cnt_clr) begin
        r_stall_cycles <= '0;
        r_flush_count  <= '0;
      end else begin
        if ((|o_stall) && (r_stall_cycles != {CW{1'b1}})) r_stall_cycles <= r_stall_cycles + 1'b1;
        if (w_apply && (r_flush_count != {CW{1'b1}})) r_flush_count <= r_flush_count + 1'b1;
      end

      // Limit of zero never arms: the counter cannot leave zero and the trip compare fails.
      if (|o_stall) begin
        if (r_wdog_cnt != WD_LIM) r_wdog_cnt <= r_wdog_cnt + 32'd1;
        if ((WD_LIM != 32'd0) && (r_wdog_cnt + 32'd1 == WD_LIM)) r_wdog_err <= 1'b1;
      end else begin
        r_wdog_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expectations,
// a monitor on the falling edge pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int M_ST = 1, M_BB = 2, M_PD = 4, M_SC = 8;
  localparam int M_FC = 16, M_WD = 32, M_PC = 64, M_FL = 128;

  typedef struct {
    string       nm;
    int          m;
    logic [5:0]  st, bb, fl;
    logic        pd;
    logic [3:0]  sc, fc;
    logic        wd;
    logic [31:0] fpc;
  } cyc_exp_t;

  typedef struct {
    string       nm;
    logic [5:0]  fl;
    logic [31:0] pc;
  } fl_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  stall_req = '0;
  logic        flush_req = 1'b0;
  logic [2:0]  flush_stage = '0;
  logic [31:0] flush_pc_in = '0;
  logic        cnt_clr = 1'b0;
  logic [5:0]  stall, bubble, flush;
  logic [31:0] flush_pc;
  logic        flush_pending;
  logic [3:0]  stall_cycles, flush_count;
  logic        wdog_err;

  cyc_exp_t cyc_q[$];
  fl_exp_t  fl_q[$];
  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .STAGES(6), .NREQ(4), .REQ_DEPTH(16'h4221), .AW(32), .CW(4), .WDOG_LIMIT(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall_req    (stall_req),
    .i_flush_req    (flush_req),
    .i_flush_stage  (flush_stage),
    .i_flush_pc     (flush_pc_in),
    .i_cnt_clr      (cnt_clr),
    .o_stall        (stall),
    .o_bubble       (bubble),
    .o_flush        (flush),
    .o_flush_pc     (flush_pc),
    .o_flush_pending(flush_pending),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count),
    .o_wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %h want %h", nm, f, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] req, input logic fr,
                      input logic [2:0] fs, input logic [31:0] pc, input logic clr);
    @(posedge clk);
    #1;
    rst = r; stall_req = req; flush_req = fr; flush_stage = fs;
    flush_pc_in = pc; cnt_clr = clr;
  endtask

  task automatic ex(input string nm, input int m, input logic [5:0] st, input logic [5:0] bb,
                    input logic [5:0] fl, input logic pd, input logic [3:0] sc,
                    input logic [3:0] fc, input logic wd, input logic [31:0] fpc);
    cyc_exp_t e;
    e.nm = nm; e.m = m; e.st = st; e.bb = bb; e.fl = fl; e.pd = pd;
    e.sc = sc; e.fc = fc; e.wd = wd; e.fpc = fpc;
    cyc_q.push_back(e);
  endtask

  task automatic exf(input string nm, input logic [5:0] fl, input logic [31:0] pc);
    fl_exp_t e;
    e.nm = nm; e.fl = fl; e.pc = pc;
    fl_q.push_back(e);
  endtask

  // Monitor: flush events are checked against the flush queue, per-cycle state against cyc_q.
  initial begin
    cyc_exp_t c;
    fl_exp_t  f;
    forever begin
      @(negedge clk);
      if (flush != 6'b0) begin
        if (fl_q.size() == 0) begin
          chk("unexpected_flush", "flush", {26'b0, flush}, 32'h0);
        end else begin
          f = fl_q.pop_front();
          chk(f.nm, "flush", {26'b0, flush}, {26'b0, f.fl});
          chk(f.nm, "flush_pc", flush_pc, f.pc);
        end
      end
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        if ((c.m & M_ST) != 0) chk(c.nm, "stall", {26'b0, stall}, {26'b0, c.st});
        if ((c.m & M_BB) != 0) chk(c.nm, "bubble", {26'b0, bubble}, {26'b0, c.bb});
        if ((c.m & M_FL) != 0) chk(c.nm, "flush", {26'b0, flush}, {26'b0, c.fl});
        if ((c.m & M_PD) != 0) chk(c.nm, "pending", {31'b0, flush_pending}, {31'b0, c.pd});
        if ((c.m & M_SC) != 0) chk(c.nm, "stall_cycles", {28'b0, stall_cycles}, {28'b0, c.sc});
        if ((c.m & M_FC) != 0) chk(c.nm, "flush_count", {28'b0, flush_count}, {28'b0, c.fc});
        if ((c.m & M_WD) != 0) chk(c.nm, "wdog_err", {31'b0, wdog_err}, {31'b0, c.wd});
        if ((c.m & M_PC) != 0) chk(c.nm, "flush_pc_hold", flush_pc, c.fpc);
      end
    end
  end

  initial begin
    // Reset with requests asserted: everything must stay quiet.
    step(1, 4'b1000, 1, 3'd3, 32'h55, 0);
    step(1, 4'b1000, 1, 3'd3, 32'h55, 0);
    ex("rst", M_ST|M_BB|M_FL|M_PD|M_SC|M_FC|M_WD|M_PC, 0, 0, 0, 0, 0, 0, 0, 0);

    // Stall depth decode.
    step(0, 4'b0001, 0, 0, 0, 0); ex("t1_req0", M_ST|M_BB|M_SC, 6'h03, 6'h04, 0, 0, 0, 0, 0, 0);
    step(0, 4'b1000, 0, 0, 0, 0); ex("t1_req3", M_ST|M_BB|M_SC, 6'h1F, 6'h20, 0, 0, 1, 0, 0, 0);
    step(0, 4'b1111, 0, 0, 0, 0); ex("t1_all", M_ST|M_BB|M_SC, 6'h1F, 6'h20, 0, 0, 2, 0, 0, 0);
    step(0, 4'b0110, 0, 0, 0, 0); ex("t1_req12", M_ST|M_BB|M_SC, 6'h07, 6'h08, 0, 0, 3, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0); ex("t1_none", M_ST|M_BB|M_SC|M_WD, 0, 0, 0, 0, 4, 0, 0, 0);

    // Immediate flushes, stage clamp, counter clear.
    step(0, 0, 1, 3'd2, 32'h100, 0); exf("t2_flush", 6'h07, 32'h100);
    ex("t2_flush", M_ST|M_BB|M_PD|M_FC, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); ex("t2_after", M_FC|M_PC|M_FL, 0, 0, 0, 0, 0, 1, 0, 32'h100);
    step(0, 0, 1, 3'd7, 32'h300, 0); exf("t2_clamp", 6'h3F, 32'h300);
    ex("t2_clamp", M_FC, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1); ex("t2_clr", M_FC|M_SC|M_PC, 0, 0, 0, 0, 4, 2, 0, 32'h300);

    // Deferral behind a deep stall.
    step(0, 4'b1000, 1, 3'd3, 32'h200, 0);
    ex("t3_c1", M_ST|M_BB|M_PD|M_FL|M_SC|M_FC, 6'h1F, 6'h20, 0, 1, 0, 0, 0, 0);
    for (int c = 2; c <= 5; c++) begin
      step(0, 4'b1000, 0, 0, 0, 0);
      ex("t3_hold", M_ST|M_PD|M_FL|M_SC, 6'h1F, 0, 0, 1, 4'(c - 1), 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0); exf("t3_rel", 6'h0F, 32'h200);
    ex("t3_rel", M_ST|M_BB|M_PD|M_SC, 0, 0, 0, 0, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); ex("t3_after", M_FC|M_PC|M_PD, 0, 0, 0, 0, 0, 1, 0, 32'h200);
    step(0, 4'b0001, 1, 3'd2, 32'h240, 0); exf("t3_fs_gt", 6'h07, 32'h240);
    ex("t3_fs_gt", M_ST|M_BB|M_PD, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0110, 1, 3'd2, 32'h250, 0); exf("t3_fs_eq", 6'h07, 32'h250);
    ex("t3_fs_eq", M_ST|M_BB|M_FC|M_SC, 0, 0, 0, 0, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0); ex("t3_cnt", M_FC|M_SC, 0, 0, 0, 0, 5, 3, 0, 0);

    // Pending replacement: larger stage wins, tie goes to the new request.
    step(0, 4'b1000, 1, 3'd2, 32'hA00, 0); ex("t4_p1", M_PD|M_FL, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 4'b1000, 1, 3'd3, 32'hB00, 0); ex("t4_p2", M_PD|M_FL, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); exf("t4_newer", 6'h0F, 32'hB00);
    step(0, 4'b1000, 1, 3'd3, 32'hC00, 0); ex("t4_p4", M_PD|M_FL, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 4'b1000, 1, 3'd1, 32'hD00, 0); ex("t4_p5", M_PD|M_FL, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); exf("t4_keep", 6'h0F, 32'hC00);
    step(0, 4'b1000, 1, 3'd2, 32'hE00, 0);
    step(0, 4'b1000, 1, 3'd2, 32'hF00, 0);
    step(0, 0, 0, 0, 0, 0); exf("t4_tie", 6'h07, 32'hF00);
    step(0, 0, 0, 0, 0, 0); ex("t4_cnt", M_FC|M_SC|M_PC, 0, 0, 0, 0, 11, 6, 0, 32'hF00);

    // Watchdog trips after 8 stalled cycles and is sticky; stall_cycles saturates.
    for (int i = 1; i <= 8; i++) begin
      step(0, 4'b0001, 0, 0, 0, 0);
      if (i == 8) ex("t5_c8", M_ST|M_WD, 6'h03, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0); ex("t5_trip", M_WD|M_SC, 0, 0, 0, 0, 15, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1); ex("t5_sticky", M_WD|M_SC, 0, 0, 0, 0, 15, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0); ex("t5_clr", M_SC|M_FC|M_WD, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset clears watchdog; long stall saturates; reset drops a deferred flush.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    ex("t6_rst", M_WD|M_SC|M_FC|M_PD|M_PC, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 4'b1000, 0, 0, 0, 0);
      if (i == 15) ex("t6_sc14", M_SC, 0, 0, 0, 0, 14, 0, 0, 0);
      if (i == 16) ex("t6_sc15", M_SC, 0, 0, 0, 0, 15, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1); ex("t6_sat", M_SC|M_WD, 0, 0, 0, 0, 15, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0); ex("t6_clr", M_SC, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 4'b1000, 1, 3'd3, 32'h700, 0); ex("t6_defer", M_PD|M_FL, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 4'b1000, 0, 0, 0, 0); ex("t6_rstmid", M_ST|M_FL|M_PD, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    ex("t6_drop", M_FL|M_PD|M_FC|M_PC, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); ex("t6_drop2", M_FL|M_PD, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("flush_q_drained", "left", fl_q.size(), 32'd0);
    chk("cyc_q_drained", "left", cyc_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
